multdiv_iter: RTL
=================

# multdiv_iter

Iterative signed 32-bit multiply/divide responder for the processor execute stage. The pipeline raises a one-cycle `ctrl_MULT` or `ctrl_DIV` request. The block latches both operands and runs radix-4 Booth multiplication (16 iterations) or non-restoring division (32 iterations). It then returns the result with a one-cycle `data_resultRDY` pulse and an exception flag, which the pipeline uses to stall and release.

## Interface
- No parameters. Width is fixed at 32 bits.
- `clock`  in  1  Rising-edge clock.
- `reset_n`  in  1  Asynchronous, active-low reset.
- `data_operandA`  in  32  Multiplicand or dividend, two's complement. Sampled only in the request cycle.
- `data_operandB`  in  32  Multiplier or divisor, two's complement. Sampled only in the request cycle.
- `ctrl_MULT`  in  1  One-cycle start-multiply request.
- `ctrl_DIV`  in  1  One-cycle start-divide request.
- `data_result`  out  32  Registered result. Holds its value until the next completion.
- `data_exception`  out  1  Registered. Valid in the `data_resultRDY` cycle and held with `data_result`.
- `data_resultRDY`  out  1  Registered completion pulse, exactly one cycle wide.
- `busy`  out  1  High while in `MULT` or `DIV`.

## Operation
- States are `IDLE`, `MULT`, `DIV` and `DONE`.
- An iteration counter runs 0..15 for `MULT` and 0..31 for `DIV`.
- Request acceptance:
  - A request is accepted in any state, including mid-operation.
  - A new request aborts the current operation silently, with no `data_resultRDY` for it.
  - Operands are latched at the same time.
- `ctrl_MULT` and `ctrl_DIV` high together: `MULT` wins.
- Multiply:
  - 64-bit accumulator. Each iteration recodes 3 bits of B (B[-1]=0) into {-2A,-A,0,+A,+2A}, adds the term, and arithmetic-shifts right by 2.
  - After 16 iterations, `data_result` = product[31:0].
  - `data_exception` = 1 iff product[63:32] differs from 32 copies of product[31].
- Divide:
  - Operates on magnitudes: |A|, |B| as 32-bit unsigned, so |0x80000000| = 2^31.
  - One quotient bit per iteration, with non-restoring add/subtract on a 33-bit partial remainder.
  - The final quotient is negated iff A[31] xor B[31].
  - Truncates toward zero. The remainder is discarded.
- Divide by zero: B == 0 at request goes directly to `DONE`, with `data_result` = 0 and `data_exception` = 1.
- Divide overflow: 0x80000000 / 0xFFFFFFFF gives `data_result` = 0x80000000 and `data_exception` = 1.
- All other divides give `data_exception` = 0.
- `DONE`: assert `data_resultRDY` for one cycle, then return to `IDLE`.
- Reset values: state `IDLE`, counter 0, `data_result` 0x00000000, `data_exception` 0, `data_resultRDY` 0, `busy` 0.
  - Reset mid-operation discards all work. No `data_resultRDY` follows.

## Timing
- Let t0 be the rising edge that samples the request. Latency L means `data_resultRDY` is high in the cycle after edge t0+L.
- Latencies:
  - Multiply: L = 17 (16 iteration edges plus the `DONE` edge).
  - Divide: L = 33.
  - Divide by zero: L = 1.
- `busy` rises after t0 and falls when `DONE` is entered. `busy` stays 0 for divide by zero.
- `data_result` and `data_exception` update on the same edge that raises `data_resultRDY`.
- Back-to-back: a request may arrive in the `DONE` cycle. The new request is accepted, and the pending `data_resultRDY` still pulses.
- Operands may change freely after t0. Their changes have no effect.

## Test plan
- Multiply: A = 7, B = 0xFFFFFFFD (-3), `ctrl_MULT` at t0. `data_resultRDY` is first high after edge t0+17 for one cycle, with `data_result` = 0xFFFFFFEB and `data_exception` = 0. `busy` is high during the iteration cycles.
- Multiply overflow: A = 0x00010000, B = 0x00010000. `data_result` = 0x00000000, `data_exception` = 1. Also A = 0x80000000, B = 1 gives 0x80000000 with `data_exception` = 0.
- Signed divide, latency 33:
  - A = 0xFFFFFFF9 (-7), B = 2 gives 0xFFFFFFFD.
  - A = 100, B = 0xFFFFFFF6 gives 0xFFFFFFF6.
  - A = 0x7FFFFFFF, B = 1 gives 0x7FFFFFFF.
  - `data_exception` = 0 in all three.
- Divide corner cases:
  - A = 5, B = 0: `data_resultRDY` after t0+1, `data_result` = 0, `data_exception` = 1.
  - A = 0x80000000, B = 0xFFFFFFFF: after t0+33, `data_result` = 0x80000000, `data_exception` = 1.
- Abort and priority:
  - Start a divide, then `ctrl_MULT` (3 × 4) 5 cycles later. Only one `data_resultRDY`, 17 cycles after the multiply request, with value 12.
  - Both ctrl signals high (A = 6, B = 3) gives result 18.
- Reset: pull `reset_n` low at cycle 10 of a divide, asynchronously mid-cycle. All outputs go to zero immediately, and no `data_resultRDY` occurs over the next 40 cycles.

Source files
------------

// File: rtl/multdiv_iter_if.sv
// Operand/control/result bundle between the execute stage and the
// iterative multiply/divide unit.
interface multdiv_iter_if;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  // Pipeline side: issues requests, consumes results.
  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );

  // Unit side: accepts requests, produces results.
  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_iter.sv
// Iterative signed 32-bit multiplier (radix-4 Booth, 16 steps) and divider
// (non-restoring on magnitudes, 32 steps) with a one-cycle completion pulse.
module multdiv_iter (
  input  logic          clock,
  input  logic          reset_n,
  multdiv_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
  typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_DIV0} op_t;

  state_t      r_state;
  state_t      w_state_next;
  op_t         r_op;
  logic [4:0]  r_cnt;

  // Booth datapath: {34-bit upper partial sum, 32-bit multiplier, B[-1]}.
  logic [66:0] r_p;
  logic [31:0] r_mcand;

  // Divider datapath.
  logic [32:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic        r_neg;
  logic        r_ovf;

  logic [31:0] r_result;
  logic        r_exception;
  logic        r_rdy;

  logic        w_start_mul;
  logic        w_start_div;
  logic        w_div_zero;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;

  assign w_start_mul = bus.ctrl_MULT;
  assign w_start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
  assign w_div_zero  = (bus.data_operandB == 32'h0);
  assign w_abs_a     = bus.data_operandA[31] ? (~bus.data_operandA + 32'd1) : bus.data_operandA;
  assign w_abs_b     = bus.data_operandB[31] ? (~bus.data_operandB + 32'd1) : bus.data_operandB;

  // ---------------------------------------------------------------------
  // Booth step: recode r_p[2:0], add the term to the upper part, shift by 2.
  // The two guard bits keep +/-2A from wrapping the upper partial sum.
  // ---------------------------------------------------------------------
  logic        [33:0] w_mc_ext;
  logic        [33:0] w_term;
  logic        [33:0] w_hi_sum;
  logic signed [66:0] w_p_sum;
  logic        [66:0] w_p_next;
  logic        [63:0] w_prod;
  logic               w_mul_ovf;

  assign w_mc_ext = {{2{r_mcand[31]}}, r_mcand};

  // NOTE: combinational blocks assign every output a default first, so no
  // path through the case can leave a value unassigned and infer a latch.
  always_comb begin
    w_term = 34'd0;
    unique case (r_p[2:0])
      3'b001, 3'b010: w_term = w_mc_ext;
      3'b011:         w_term = {w_mc_ext[32:0], 1'b0};
      3'b100:         w_term = ~{w_mc_ext[32:0], 1'b0} + 34'd1;
      3'b101, 3'b110: w_term = ~w_mc_ext + 34'd1;
      default:        w_term = 34'd0;
    endcase
  end

  assign w_hi_sum  = r_p[66:33] + w_term;
  assign w_p_sum   = {w_hi_sum, r_p[32:0]};
  assign w_p_next  = w_p_sum >>> 2;
  assign w_prod    = r_p[64:1];
  assign w_mul_ovf = (w_prod[63:32] != {32{w_prod[31]}});

  // ---------------------------------------------------------------------
  // Non-restoring step: shift in the next dividend bit, then subtract the
  // divisor if the remainder is non-negative, otherwise add it back.
  // ---------------------------------------------------------------------
  logic [32:0] w_rem_sh;
  logic [32:0] w_rem_next;
  logic [31:0] w_quo_next;
  logic [31:0] w_quo_signed;

  assign w_rem_sh     = {r_rem[31:0], r_quo[31]};
  assign w_rem_next   = r_rem[32] ? (w_rem_sh + {1'b0, r_dvs})
                                  : (w_rem_sh - {1'b0, r_dvs});
  assign w_quo_next   = {r_quo[30:0], ~w_rem_next[32]};
  assign w_quo_signed = r_neg ? (~r_quo + 32'd1) : r_quo;

  // ---------------------------------------------------------------------
  // Control FSM.
  // ---------------------------------------------------------------------
  // NOTE: all clocked state uses non-blocking assignment so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_start_mul) begin
      w_state_next = MULT;
    end else if (w_start_div) begin
      w_state_next = w_div_zero ? DONE : DIV;
    end else begin
      unique case (r_state)
        MULT:    if (r_cnt == 5'd15) w_state_next = DONE;
        DIV:     if (r_cnt == 5'd31) w_state_next = DONE;
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Operand capture and iteration datapath. A new request always wins, so
  // an in-flight operation is overwritten without completing.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op    <= OP_MUL;
      r_cnt   <= 5'd0;
      r_p     <= '0;
      r_mcand <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_start_mul) begin
      r_op    <= OP_MUL;
      r_cnt   <= 5'd0;
      r_p     <= {34'd0, bus.data_operandB, 1'b0};
      r_mcand <= bus.data_operandA;
    end else if (w_start_div) begin
      r_op    <= w_div_zero ? OP_DIV0 : OP_DIV;
      r_cnt   <= 5'd0;
      r_rem   <= '0;
      r_quo   <= w_abs_a;
      r_dvs   <= w_abs_b;
      r_neg   <= bus.data_operandA[31] ^ bus.data_operandB[31];
      r_ovf   <= (bus.data_operandA == 32'h8000_0000) &&
                 (bus.data_operandB == 32'hFFFF_FFFF);
    end else if (r_state == MULT) begin
      r_p     <= w_p_next;
      r_cnt   <= r_cnt + 5'd1;
    end else if (r_state == DIV) begin
      r_rem   <= w_rem_next;
      r_quo   <= w_quo_next;
      r_cnt   <= r_cnt + 5'd1;
    end else begin
      r_cnt   <= 5'd0;
    end
  end

  // ---------------------------------------------------------------------
  // Result registers: loaded on the DONE edge, which also raises the pulse.
  // This is independent of any request arriving in the same cycle.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_result    <= 32'h0;
      r_exception <= 1'b0;
      r_rdy       <= 1'b0;
    end else if (r_state == DONE) begin
      r_rdy <= 1'b1;
      unique case (r_op)
        OP_MUL: begin
          r_result    <= w_prod[31:0];
          r_exception <= w_mul_ovf;
        end
        OP_DIV: begin
          r_result    <= w_quo_signed;
          r_exception <= r_ovf;
        end
        default: begin
          r_result    <= 32'h0;
          r_exception <= 1'b1;
        end
      endcase
    end else begin
      r_rdy <= 1'b0;
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exception;
  assign bus.data_resultRDY = r_rdy;
  assign bus.busy           = (r_state == MULT) || (r_state == DIV);

endmodule
